// File: rtl/mpsoc_msi_wb_pkg.sv
// Shared types and Wishbone encodings for the N-by-M shared-bus interconnect.
package mpsoc_msi_wb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ERR  = 2'd2
    } bus_state_e;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;

endpackage

// File: rtl/mpsoc_msi_wb_arbiter_rr.sv
// Round-robin arbiter: registered one-hot grant plus encoded index.
// load_i picks the first requester at or after the pointer; advance_i drops the grant and moves
// the pointer one past the released owner.
module mpsoc_msi_wb_arbiter_rr #(
    parameter int unsigned N = 3,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [N-1:0]  req_i,
    input  logic          load_i,
    input  logic          advance_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o
);

    logic [N-1:0]  grant_q, grant_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] pick;
    logic          found;

    // Search from the pointer upward, wrapping at N-1, for the first requester.
    always_comb begin
        int cand;
        found = 1'b0;
        pick  = ptr_q;
        cand  = 0;
        for (int i = 0; i < int'(N); i++) begin
            cand = int'(ptr_q) + i;
            if (cand >= int'(N)) cand = cand - int'(N);
            if (!found && req_i[cand]) begin
                found = 1'b1;
                pick  = IW'(cand);
            end
        end
    end

    // Next grant / pointer.
    always_comb begin
        grant_d = grant_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        if (load_i && found) begin
            grant_d       = '0;
            grant_d[pick] = 1'b1;
            idx_d         = pick;
        end else if (advance_i) begin
            grant_d = '0;
            ptr_d   = (idx_q == IW'(N - 1)) ? '0 : idx_q + 1'b1;
        end
    end

    // Arbiter state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            grant_q <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
        end else begin
            grant_q <= grant_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
        end
    end

    assign grant_o = grant_q;
    assign idx_o   = idx_q;

endmodule

// File: rtl/mpsoc_msi_wb_bus_nxm.sv
// Wishbone B3 shared bus: NM masters, NS slaves, round-robin ownership per bus cycle,
// mask/base decode, and a bus error for unmapped addresses or slaves that never answer.
module mpsoc_msi_wb_bus_nxm
    import mpsoc_msi_wb_pkg::*;
#(
    parameter int unsigned         NM         = 3,
    parameter int unsigned         NS         = 2,
    parameter int unsigned         AW         = 32,
    parameter int unsigned         DW         = 32,
    parameter logic [NS*AW-1:0]    SLAVE_BASE = {32'h90000000, 32'h00000000},
    parameter logic [NS*AW-1:0]    SLAVE_MASK = {32'hFFFFFFF8, 32'hFE000000},
    parameter int unsigned         TIMEOUT    = 255
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic [NM*AW-1:0]      m_adr_i,
    input  logic [NM*DW-1:0]      m_dat_i,
    input  logic [NM*DW/8-1:0]    m_sel_i,
    input  logic [NM-1:0]         m_we_i,
    input  logic [NM-1:0]         m_cyc_i,
    input  logic [NM-1:0]         m_stb_i,
    input  logic [NM*3-1:0]       m_cti_i,
    input  logic [NM*2-1:0]       m_bte_i,
    output logic [DW-1:0]         m_dat_o,
    output logic [NM-1:0]         m_ack_o,
    output logic [NM-1:0]         m_err_o,
    output logic [NM-1:0]         m_rty_o,
    output logic [AW-1:0]         s_adr_o,
    output logic [DW-1:0]         s_dat_o,
    output logic [DW/8-1:0]       s_sel_o,
    output logic                  s_we_o,
    output logic [2:0]            s_cti_o,
    output logic [1:0]            s_bte_o,
    output logic [NS-1:0]         s_cyc_o,
    output logic [NS-1:0]         s_stb_o,
    input  logic [NS*DW-1:0]      s_dat_i,
    input  logic [NS-1:0]         s_ack_i,
    input  logic [NS-1:0]         s_err_i,
    input  logic [NS-1:0]         s_rty_i,
    output logic [NM-1:0]         grant_o
);

    localparam int unsigned SW  = DW / 8;
    localparam int unsigned MW  = (NM > 1) ? $clog2(NM) : 1;
    localparam int unsigned SIW = (NS > 1) ? $clog2(NS) : 1;
    localparam int unsigned TW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    bus_state_e      state_q, state_d;
    logic [MW-1:0]   gidx;
    logic            load, advance;
    logic [TW-1:0]   wd_q, wd_d;

    logic [AW-1:0]   g_adr;
    logic [DW-1:0]   g_dat;
    logic [SW-1:0]   g_sel;
    logic [2:0]      g_cti;
    logic [1:0]      g_bte;
    logic            g_we, g_cyc, g_stb;
    logic            hit_any, term;
    logic [SIW-1:0]  hit_idx;

    mpsoc_msi_wb_arbiter_rr #(
        .N (NM)
    ) u_arb (
        .clk_i     (wb_clk_i),
        .rst_ni    (wb_rst_i),
        .req_i     (m_cyc_i),
        .load_i    (load),
        .advance_i (advance),
        .grant_o   (grant_o),
        .idx_o     (gidx)
    );

    assign g_adr = m_adr_i[gidx*AW +: AW];
    assign g_dat = m_dat_i[gidx*DW +: DW];
    assign g_sel = m_sel_i[gidx*SW +: SW];
    assign g_cti = m_cti_i[gidx*3 +: 3];
    assign g_bte = m_bte_i[gidx*2 +: 2];
    assign g_we  = m_we_i[gidx];
    // Only meaningful while someone owns the bus; gidx is stale in IDLE.
    assign g_cyc = m_cyc_i[gidx] & (state_q != IDLE);
    assign g_stb = g_cyc & m_stb_i[gidx];

    // Address decode every beat; descending scan so the lowest matching slave wins.
    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int s = int'(NS) - 1; s >= 0; s--) begin
            if ((g_adr & SLAVE_MASK[s*AW +: AW]) == (SLAVE_BASE[s*AW +: AW] & SLAVE_MASK[s*AW +: AW]))
            begin
                hit_any = 1'b1;
                hit_idx = SIW'(s);
            end
        end
    end

    assign term = hit_any & (s_ack_i[hit_idx] | s_err_i[hit_idx] | s_rty_i[hit_idx]);

    // Ownership FSM and watchdog next-state.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        advance = 1'b0;
        wd_d    = '0;
        case (state_q)
            IDLE: begin
                if (|m_cyc_i) begin
                    load    = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (!g_cyc) begin
                    advance = 1'b1;
                    state_d = IDLE;
                end else if (g_stb && !hit_any) begin
                    state_d = ERR;
                end else if (g_stb && !term && (TIMEOUT != 0)) begin
                    if (wd_q == TW'(TIMEOUT)) state_d = ERR;
                    else                      wd_d    = wd_q + 1'b1;
                end
            end
            ERR:     state_d = BUSY;
            default: state_d = IDLE;
        endcase
    end

    // FSM and watchdog registers.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_q <= IDLE;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
        end
    end

    // Bus routing: owner's request to the decoded slave, its terminations back to the owner only.
    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        s_cti_o = '0;
        s_bte_o = '0;
        s_cyc_o = '0;
        s_stb_o = '0;
        m_dat_o = '0;
        m_ack_o = '0;
        m_err_o = '0;
        m_rty_o = '0;
        if (state_q != IDLE) begin
            s_adr_o = g_adr;
            s_dat_o = g_dat;
            s_sel_o = g_sel;
            s_we_o  = g_we;
            s_cti_o = g_cti;
            s_bte_o = g_bte;
        end
        if (state_q == BUSY && hit_any) begin
            s_cyc_o[hit_idx] = g_cyc;
            s_stb_o[hit_idx] = g_stb;
            m_dat_o          = s_dat_i[hit_idx*DW +: DW];
            m_ack_o[gidx]    = g_cyc & s_ack_i[hit_idx];
            m_err_o[gidx]    = g_cyc & s_err_i[hit_idx];
            m_rty_o[gidx]    = g_cyc & s_rty_i[hit_idx];
        end
        if (state_q == ERR) m_err_o[gidx] = 1'b1;
    end

endmodule
